// File: rtl/riscv_pkg.sv
// Shared RV32 widths and the fetch packet handed from fetch to decode.
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, reads the combinational ROM and
// holds one {pc, instr} packet for decode behind a valid/ready handshake.
module pc_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              ROM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    rom_a,
    input  logic [INSTR_W-1:0] rom_rd,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               halted,
    output logic               fault
);
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(ROM_DEPTH * INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc;
    fetch_pkt_t      out_q;
    logic            out_valid_q;
    logic            fault_q;
    logic            in_range;
    logic            load_en;

    assign in_range  = (pc < PC_LIMIT);
    assign halted    = fault_q | ~in_range;
    assign load_en   = ~out_valid_q | out_ready;
    assign rom_a     = pc;
    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign out_instr = out_q.instr;
    assign fault     = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else if (redirect_valid) begin
            // Any redirect flushes the held packet; a faulted fetch never moves pc again.
            out_valid_q <= 1'b0;
            if (redirect_pc[1:0] != 2'b00)
                fault_q <= 1'b1;
            else if (!fault_q)
                pc <= redirect_pc;
        end else if (load_en) begin
            if (!halted) begin
                out_q       <= '{pc: pc, instr: rom_rd};
                out_valid_q <= 1'b1;
                pc          <= pc + PC_STEP;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboarded bench for pc_fetch: stimulus pushes expected packets, monitors
// pop them on each handshake; flag/latency checks are made inline.
module tb_pc_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic [31:0] rom_a, rom_rd, rom_a1, rom_rd1;
    logic        redirect_valid, redirect_valid1;
    logic [31:0] redirect_pc, redirect_pc1;
    logic        out_valid, out_ready, out_valid1, out_ready1;
    logic [31:0] out_pc, out_instr, out_pc1, out_instr1;
    logic        halted, fault, halted1, fault1;

    int checks = 0;
    int failures = 0;
    fetch_pkt_t q0[$];
    fetch_pkt_t q1[$];

    always #5 clk = ~clk;

    // ROM image: word i holds i
    assign rom_rd  = {2'b00, rom_a[31:2]};
    assign rom_rd1 = {2'b00, rom_a1[31:2]};

    pc_fetch #(.RESET_PC(32'h0), .ROM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .rom_a(rom_a), .rom_rd(rom_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .halted(halted), .fault(fault)
    );

    pc_fetch #(.RESET_PC(32'h3F8), .ROM_DEPTH(256)) dut1 (
        .clk(clk), .rst(rst1), .rom_a(rom_a1), .rom_rd(rom_rd1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_pc(out_pc1),
        .out_instr(out_instr1), .halted(halted1), .fault(fault1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input logic [31:0] pc);
        q0.push_back('{pc: pc, instr: {2'b00, pc[31:2]}});
    endtask

    task automatic push1(input logic [31:0] pc);
        q1.push_back('{pc: pc, instr: {2'b00, pc[31:2]}});
    endtask

    // A redirect cycle flushes the held packet, so it is not a transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                fetch_pkt_t e;
                e = q0.pop_front();
                chk("dut0_xfer_pc", out_pc, e.pc);
                chk("dut0_xfer_instr", out_instr, e.instr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && out_valid1 && out_ready1 && !redirect_valid1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_pc", out_pc1, 32'hFFFF_FFFF);
            end else begin
                fetch_pkt_t e;
                e = q1.pop_front();
                chk("dut1_xfer_pc", out_pc1, e.pc);
                chk("dut1_xfer_instr", out_instr1, e.instr);
            end
        end
    end

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        out_ready = 1'b1; out_ready1 = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        redirect_valid1 = 1'b0; redirect_pc1 = '0;
        cyc(2);

        // Reset state, then full sweep of the ROM
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_rom_a", rom_a, 32'd0);
        for (int i = 0; i < 256; i++) push0(32'(i * 4));
        rst = 1'b0;
        cyc(260);
        chk("sweep_end_valid", {31'b0, out_valid}, 32'd0);
        chk("sweep_end_halted", {31'b0, halted}, 32'd1);
        chk("sweep_queue_drained", 32'(q0.size()), 32'd0);

        // Backpressure: hold packet 0 for 5 cycles
        rst = 1'b1; out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        push0(32'h0); push0(32'h4); push0(32'h8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, 32'h0);
            chk("stall_instr", out_instr, 32'h0);
            chk("stall_rom_a", rom_a, 32'h4);
            cyc();
        end
        out_ready = 1'b1;
        cyc(3);

        // Aligned redirect while a packet is being accepted
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0; out_ready = 1'b0;
        chk("redir_bubble_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_rom_a", rom_a, 32'h100);
        cyc();
        chk("redir_tgt_valid", {31'b0, out_valid}, 32'd1);
        chk("redir_tgt_pc", out_pc, 32'h100);
        chk("redir_tgt_instr", out_instr, 32'h40);
        push0(32'h100);
        out_ready = 1'b1;
        cyc();

        // Misaligned redirect: sticky fault, later redirects do not restart
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cyc();
        redirect_valid = 1'b0;
        chk("fault_set", {31'b0, fault}, 32'd1);
        chk("fault_halted", {31'b0, halted}, 32'd1);
        chk("fault_valid", {31'b0, out_valid}, 32'd0);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fault_hold_valid", {31'b0, out_valid}, 32'd0);
            chk("fault_hold_fault", {31'b0, fault}, 32'd1);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("fault_clr", {31'b0, fault}, 32'd0);
        chk("fault_clr_halted", {31'b0, halted}, 32'd0);

        // Mid-stream reset with out_ready low
        push0(32'h0); push0(32'h4); push0(32'h8);
        cyc(4);
        out_ready = 1'b0;
        chk("pre_rst_pc", out_pc, 32'hC);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_rom_a", rom_a, 32'h0);
        push0(32'h0);
        out_ready = 1'b1;
        cyc(2);
        out_ready = 1'b0;
        chk("dut0_queue_drained", 32'(q0.size()), 32'd0);

        // RESET_PC near the end of the ROM: two packets, then halt
        push1(32'h3F8); push1(32'h3FC);
        rst1 = 1'b0; out_ready1 = 1'b1;
        cyc(4);
        chk("tail_valid", {31'b0, out_valid1}, 32'd0);
        chk("tail_halted", {31'b0, halted1}, 32'd1);
        chk("tail_fault", {31'b0, fault1}, 32'd0);
        push1(32'h0);
        redirect_valid1 = 1'b1; redirect_pc1 = 32'h0;
        cyc();
        redirect_valid1 = 1'b0;
        chk("resume_halted", {31'b0, halted1}, 32'd0);
        cyc(2);
        out_ready1 = 1'b0;
        chk("resume_next_instr", out_instr1, 32'h1);
        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end that drives the combinational `pc_rom` and hands fetched instructions to decode. It owns the program counter, issues the ROM byte address, captures `{pc, instruction}` into a one-entry output register, and presents it to decode with a valid/ready handshake. Decode and execute can request control-flow changes through a redirect port.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `ROM_DEPTH`, default `256`: ROM depth in 32-bit words. The fetchable byte range is `[0, ROM_DEPTH*4)`.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset, synchronous, active-high.
- `rom_a`  out  32  Byte address to `pc_rom` (`A`). Combinationally equal to `pc`.
- `rom_rd`  in  32  Word from `pc_rom` (`RD`). Valid in the same cycle as `rom_a`.
- `redirect_valid`  in  1  Redirect request, honoured in the cycle it is high.
- `redirect_pc`  in  32  Redirect target byte address.
- `out_valid`  out  1  `out_pc` and `out_instr` hold a fetched instruction.
- `out_ready`  in  1  Decode accepts the instruction this cycle.
- `out_pc`  out  32  Byte address of the held instruction.
- `out_instr`  out  32  Held instruction word.
- `halted`  out  1  Fetch has stopped: `pc` is out of range, or `fault` is set.
- `fault`  out  1  Sticky flag: a misaligned redirect was received. Cleared only by `rst`.

## Operation
- State:
  - `pc` (32 bits).
  - Output register: `out_valid`, `out_pc`, `out_instr`.
  - `fault`.
- Reset values: `pc = RESET_PC`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `fault = 0`.
- `in_range = (pc < ROM_DEPTH*4)`. This is an unsigned 32-bit compare.
- `halted = fault | ~in_range`. It is combinational.
- `load_en = ~out_valid | out_ready`. This is the output-register load enable.
- Per-cycle priority, highest first:
  1. `rst` → apply the reset values.
  2. `redirect_valid` with `redirect_pc[1:0] == 0` → `pc <= redirect_pc`, `out_valid <= 0`. The instruction being held is dropped even if `out_ready` is high, and nothing is fetched this cycle.
  3. `redirect_valid` with `redirect_pc[1:0] != 0` → `fault <= 1`, `out_valid <= 0`, `pc` unchanged.
  4. `load_en & ~halted` → `out_pc <= pc`, `out_instr <= rom_rd`, `out_valid <= 1`, `pc <= pc + 4`.
  5. `load_en & halted` → `out_valid <= 0`.
  6. Otherwise (stalled) → hold everything.
- PC arithmetic is 32-bit modular: `32'hFFFF_FFFC + 4` wraps to `0`. That wrap is only reachable through a redirect above the ROM range, which halts fetch anyway.
- Once `fault` is set, fetch never restarts. Redirects are ignored except that they keep `out_valid` low. Only `rst` clears `fault`.
- A redirect to an out-of-range aligned address is legal and is not a fault. The block sets `halted` and produces no output.
- An instruction is transferred only when `out_valid & out_ready` at the clock edge. While `out_valid` is high and `out_ready` is low, `out_pc` and `out_instr` are stable.

## Timing
- Fetch latency: 1 cycle. The ROM word at `pc` in cycle N appears on `out_instr` in cycle N+1.
- After reset deasserts, the first `out_valid` is seen in the cycle after the first non-reset edge.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- Redirect penalty: the redirect cycle, then one bubble (`out_valid = 0`), then the target instruction in the following cycle.
- `rst` asserted mid-stream: `out_valid = 0` in the next cycle. Fetch then restarts from `RESET_PC`.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN = 32`.
  - `INSTR_W = 32`.
  - `INSTR_BYTES = 4`.
  - A `fetch_pkt_t` struct of `{pc, instr}`, for reuse by the decode-stage input register.
- Single module, no sub-modules. The output register is a plain one-entry pipeline stage; no skid buffer is required because the ROM is combinational.

## Test plan
All scenarios use a ROM image where word i holds value i, and `RESET_PC = 0` unless stated otherwise.
- Reset, then hold `out_ready = 1` for 260 cycles → 256 transfers with `out_pc = 4*i` and `out_instr = i` for i = 0..255. Then `out_valid = 0` and `halted = 1`.
- After the first valid, drop `out_ready` for 5 cycles → `out_pc = 0` and `out_instr = 0` hold, `rom_a` stays `4`. After release, the next transfers are 0, then 1, then 2, with no loss or duplication.
- With `out_valid = 1` and `out_ready = 1`, pulse a redirect to `0x100` → the next cycle has `out_valid = 0`. The cycle after that has `out_pc = 0x100` and `out_instr = 0x40`.
- Pulse a redirect to `0x102` → `fault = 1` and `halted = 1` from the next cycle. `out_valid` stays 0 through a later aligned redirect, until `rst`.
- With `RESET_PC = 0x3F8` → exactly two transfers (`0xFE`, then `0xFF`), then `halted = 1`. A redirect to `0x0` resumes fetch with `out_instr = 0`.
- Assert `rst` for 1 cycle mid-stream with `out_ready` low → next cycle `out_valid = 0` and `rom_a = RESET_PC`. The first transfer after that is `out_instr = 0`.
